mem_loader: RTL

- Upstream feeder for mem_sys.
- Accepts a serial 1-bit stream of network parameters over a valid/ready handshake.
- Writes the stream in order into weight banks 0..3 (via sel_w), then into input bank 0 (via sel_x), generating we/address/data for mem_sys.
- Replaces bench-driven loading, so the downstream compute stage sees a fully populated memory once done fires.

---
 rtl/mem_loader_pkg.sv | 13 +
 rtl/loader_seq_counter.sv | 44 ++++
 rtl/mem_loader.sv | 96 +++++++++
 3 files changed

// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: FSM encoding, bank count and per-bank length lookup shared by mem_loader and its counter.
package mem_loader_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    LOAD_X = 2'd2,
    FINISH = 2'd3
  } state_t;
  localparam int N_W_BANKS = 4;
  function automatic int bank_len(input logic [1:0] n, input int l0, input int l1, input int l2, input int l3);
    return (n == 2'd0) ? l0 : (n == 2'd1) ? l1 : (n == 2'd2) ? l2 : l3;
  endfunction
endpackage

// File: rtl/loader_seq_counter.sv
// loader_seq_counter: addr/bank sequencer with per-bank wrap and last-element flags for weight and input phases.
module loader_seq_counter
  import mem_loader_pkg::*;
#(
  parameter int W_ADDR_LEN = 20,
  parameter int W0_LEN     = 10,
  parameter int W1_LEN     = 10,
  parameter int W2_LEN     = 10,
  parameter int W3_LEN     = 10,
  parameter int X_LEN      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  input  logic                  x_phase,
  output logic [W_ADDR_LEN-1:0] addr,
  output logic [1:0]            bank,
  output logic                  last_w,
  output logic                  last_x
);
  logic [W_ADDR_LEN-1:0] lim_w;
  logic [W_ADDR_LEN-1:0] lim_x;
  logic                  last_bank;
  always_comb begin
    lim_w     = W_ADDR_LEN'(bank_len(bank, W0_LEN, W1_LEN, W2_LEN, W3_LEN) - 1);
    lim_x     = W_ADDR_LEN'(X_LEN - 1);
    last_bank = addr == lim_w;
    last_w    = last_bank && bank == 2'(N_W_BANKS - 1);
    last_x    = addr == lim_x;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
      bank <= '0;
    end else if (clr) begin
      addr <= '0;
      bank <= '0;
    end else if (inc) begin
      addr <= (x_phase ? last_x : last_bank) ? '0 : addr + 1'b1;
      if (!x_phase && last_bank) bank <= bank + 1'b1;
    end
  end
endmodule

// File: rtl/mem_loader.sv
// mem_loader: streams serial parameter bits into weight banks 0..3 then input bank 0 of mem_sys.
// Optional MEM_LOADER_POPCOUNT_EN adds a ones_count checksum output.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int W_ADDR_LEN = 20,
  parameter int X_ADDR_LEN = 10,
  parameter int W_SEL_LEN  = 2,
  parameter int X_SEL_LEN  = 2,
  parameter int W0_LEN     = 10,
  parameter int W1_LEN     = 10,
  parameter int W2_LEN     = 10,
  parameter int W3_LEN     = 10,
  parameter int X_LEN      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_bit,
  output logic                  we_w,
  output logic                  we_x,
  output logic [W_ADDR_LEN-1:0] address_w,
  output logic [X_ADDR_LEN-1:0] address_x,
  output logic                  data_in,
  output logic [W_SEL_LEN-1:0]  sel_w,
  output logic [X_SEL_LEN-1:0]  sel_x,
  output logic                  busy,
`ifdef MEM_LOADER_POPCOUNT_EN
  output logic [W_ADDR_LEN+2:0] ones_count,
`endif
  output logic                  done
);
  state_t                state, nxt;
  logic                  xfer, begin_seq, last_w, last_x;
  logic [W_ADDR_LEN-1:0] addr;
  logic [1:0]            bank;
  loader_seq_counter #(
    .W_ADDR_LEN(W_ADDR_LEN), .W0_LEN(W0_LEN), .W1_LEN(W1_LEN),
    .W2_LEN(W2_LEN), .W3_LEN(W3_LEN), .X_LEN(X_LEN)
  ) u_cnt (
    .clk(clk), .rst(rst), .clr(begin_seq), .inc(xfer), .x_phase(state == LOAD_X),
    .addr(addr), .bank(bank), .last_w(last_w), .last_x(last_x)
  );
  // FINISH is entered on the final transfer edge, so done lines up with the last registered we_x.
  always_comb begin
    nxt       = state;
    in_ready  = state == LOAD_W || state == LOAD_X;
    xfer      = in_valid && in_ready;
    begin_seq = state == IDLE && start;
    busy      = state != IDLE;
    done      = state == FINISH;
    case (state)
      IDLE:    nxt = start ? LOAD_W : IDLE;
      LOAD_W:  nxt = (xfer && last_w) ? LOAD_X : LOAD_W;
      LOAD_X:  nxt = (xfer && last_x) ? FINISH : LOAD_X;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_w      <= 1'b0;
      we_x      <= 1'b0;
      address_w <= '0;
      address_x <= '0;
      data_in   <= 1'b0;
      sel_w     <= '0;
      sel_x     <= '0;
    end else begin
      we_w <= xfer && state == LOAD_W;
      we_x <= xfer && state == LOAD_X;
      if (xfer) begin
        data_in <= in_bit;
        if (state == LOAD_W) begin
          address_w <= addr;
          sel_w     <= W_SEL_LEN'(bank);
        end else begin
          address_x <= addr[X_ADDR_LEN-1:0];
          sel_x     <= '0;
        end
      end
    end
  end
`ifdef MEM_LOADER_POPCOUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ones_count <= '0;
    else if (begin_seq) ones_count <= '0;
    else if (xfer && in_bit) ones_count <= ones_count + 1'b1;
  end
`endif
endmodule
